// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard line deserialiser: synchronises ps2_clk/ps2_dat, assembles 11-bit frames,
// checks start/odd-parity/stop and strobes each good frame, with an inactivity timeout.
module ps2_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] data,
  output logic        data_valid,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Odd parity over scan code plus parity bit.
  function automatic logic parity_ok(input logic [10:0] frame);
    return ^frame[9:1];
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_prev_r;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall_s;
  logic                   tmo_hit_s;
  logic [10:0]            frame_s;

  state_t        state_r, state_n;
  logic [10:0]   shift_r, shift_n;
  logic [3:0]    cnt_r, cnt_n;
  logic [TW-1:0] tmo_r, tmo_n;
  logic [10:0]   data_r, data_n;
  logic          dv_r, dv_n;
  logic          pe_r, pe_n;
  logic          fe_r, fe_n;

  assign clk_s     = clk_sync_r[SYNC_STAGES-1];
  assign dat_s     = dat_sync_r[SYNC_STAGES-1];
  assign fall_s    = clk_prev_r & ~clk_s;
  assign tmo_hit_s = (state_r == RECV) && (tmo_r == TMO_LAST);
  assign frame_s   = {dat_s, shift_r[10:1]};

  // Input synchronisers and previous-clock flop for fall detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_r <= clk_s;
    end
  end

  // Frame state, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      shift_r <= 11'h000;
      cnt_r   <= 4'd0;
      tmo_r   <= '0;
      data_r  <= 11'h000;
      dv_r    <= 1'b0;
      pe_r    <= 1'b0;
      fe_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      shift_r <= shift_n;
      cnt_r   <= cnt_n;
      tmo_r   <= tmo_n;
      data_r  <= data_n;
      dv_r    <= dv_n;
      pe_r    <= pe_n;
      fe_r    <= fe_n;
    end
  end

  // Next-state logic; the verdict is registered from the completing bit so it is visible during CHECK.
  always_comb begin
    state_n = state_r;
    shift_n = shift_r;
    cnt_n   = cnt_r;
    tmo_n   = tmo_r;
    data_n  = data_r;
    dv_n    = 1'b0;
    pe_n    = 1'b0;
    fe_n    = 1'b0;
    case (state_r)
      IDLE: begin
        tmo_n = '0;
        if (fall_s && !dat_s) begin
          shift_n = frame_s;
          cnt_n   = 4'd1;
          state_n = RECV;
        end else begin
          cnt_n   = 4'd0;
        end
      end
      RECV: begin
        if (tmo_hit_s) begin
          // Timeout wins over a simultaneous fall; that bit is dropped.
          fe_n    = 1'b1;
          state_n = IDLE;
          cnt_n   = 4'd0;
          tmo_n   = '0;
        end else if (fall_s) begin
          shift_n = frame_s;
          cnt_n   = cnt_r + 4'd1;
          tmo_n   = '0;
          if (cnt_r == 4'd10) begin
            state_n = CHECK;
            if (!frame_s[10]) begin
              fe_n = 1'b1;
            end else if (!parity_ok(frame_s)) begin
              pe_n = 1'b1;
            end else begin
              data_n = frame_s;
              dv_n   = 1'b1;
            end
          end else begin
            state_n = RECV;
          end
        end else begin
          tmo_n = tmo_r + TW'(1);
        end
      end
      CHECK: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
        tmo_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
        tmo_n   = '0;
      end
    endcase
  end

  assign data       = data_r;
  assign data_valid = dv_r;
  assign parity_err = pe_r;
  assign frame_err  = fe_r;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver; expected strobes are queued as frames are sent
// and checked by a monitor when the DUT raises a strobe.
module tb_ps2_frame_receiver;

  localparam int HALF = 20;

  typedef struct {
    logic [2:0]  kind;   // {frame_err, parity_err, data_valid}
    logic [10:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] data;
  logic        data_valid;
  logic        parity_err;
  logic        frame_err;

  exp_t        exp_q[$];
  logic [10:0] model_data = 11'h000;
  int          tests = 0;
  int          fails = 0;
  logic [2:0]  prev_kind = 3'b000;

  ps2_frame_receiver #(.TIMEOUT_CYCLES(200), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .data(data), .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] mk(input logic [7:0] scan, input logic par, input logic stop);
    return {stop, par, scan, 1'b0};
  endfunction

  task automatic push(input logic [2:0] kind, input logic [10:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = frame[i];
      repeat (HALF) @(posedge clock);
      #1 ps2_clk = 1'b0;
      repeat (HALF) @(posedge clock);
      #1 ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clock);
      n++;
    end
    repeat (5) @(posedge clock);
    #1;
    tests++;
    assert (exp_q.size() === 0) else begin
      fails++;
      $error("FAIL %s_drain: pending=%0d required=0", tag, exp_q.size());
    end
    tests++;
    assert (data === model_data) else begin
      fails++;
      $error("FAIL %s_data: got=%h required=%h", tag, data, model_data);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clock) begin
    logic [2:0] k;
    exp_t e;
    k = {frame_err, parity_err, data_valid};
    if (!reset && k != 3'b000) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_strobe: got=%b required=none", k);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (k === e.kind) else begin
          fails++;
          $error("FAIL strobe_kind: got=%b required=%b", k, e.kind);
        end
        tests++;
        assert (data === e.data) else begin
          fails++;
          $error("FAIL strobe_data: got=%h required=%h", data, e.data);
        end
      end
      tests++;
      assert ((k & prev_kind) === 3'b000) else begin
        fails++;
        $error("FAIL strobe_width: got=%b after %b required single-cycle", k, prev_kind);
      end
    end
    prev_kind = reset ? 3'b000 : k;
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    tests++;
    assert ({data, data_valid, parity_err, frame_err} === 14'h0000) else begin
      fails++;
      $error("FAIL reset_outputs: got=%h required=0", {data, data_valid, parity_err, frame_err});
    end
    reset = 1'b0;
    repeat (5) @(posedge clock);

    // 1: good 0x23
    model_data = 11'h446;
    push(3'b001, 11'h446);
    send_bits(mk(8'h23, 1'b0, 1'b1), 11);
    drain("good_23");

    // 2: bad parity
    push(3'b010, 11'h446);
    send_bits(mk(8'h23, 1'b1, 1'b1), 11);
    drain("parity");

    // 3: bad stop
    push(3'b100, 11'h446);
    send_bits(mk(8'h4B, 1'b1, 1'b0), 11);
    drain("stop");

    // 4: timeout then good 0x4B
    push(3'b100, 11'h446);
    send_bits(mk(8'h4B, 1'b1, 1'b1), 5);
    repeat (250) @(posedge clock);
    drain("timeout");
    model_data = 11'h696;
    push(3'b001, 11'h696);
    send_bits(mk(8'h4B, 1'b1, 1'b1), 11);
    drain("after_timeout");

    // 5: reset mid-frame
    send_bits(mk(8'h4B, 1'b1, 1'b1), 6);
    #1 reset = 1'b1;
    #1;
    tests++;
    assert ({data, data_valid, parity_err, frame_err} === 14'h0000) else begin
      fails++;
      $error("FAIL midframe_reset: got=%h required=0", {data, data_valid, parity_err, frame_err});
    end
    model_data = 11'h000;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    model_data = 11'h446;
    push(3'b001, 11'h446);
    send_bits(mk(8'h23, 1'b0, 1'b1), 11);
    drain("after_reset");

    // 6: glitch while idle, then good 0x4B
    send_bits(11'h7FF, 1);
    repeat (50) @(posedge clock);
    drain("glitch");
    model_data = 11'h696;
    push(3'b001, 11'h696);
    send_bits(mk(8'h4B, 1'b1, 1'b1), 11);
    drain("after_glitch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
